// File: rtl/vram_fetch_arbiter.sv
// vram_fetch_arbiter: shares one 16-bit memory port between paired video fetches (priority) and CPU accesses.
module vram_fetch_arbiter #(
  parameter int AW       = 19,
  parameter int MAX_WAIT = 6
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          fetch_en,
  input  logic [AW-1:0] vram_addr1,
  input  logic [AW-1:0] vram_addr2,
  output logic [15:0]   vram_dout1,
  output logic [15:0]   vram_dout2,
  output logic          vram_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_be,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_din,
  output logic [15:0]   cpu_dout,
  output logic          cpu_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [1:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  input  logic [15:0]   mem_dout,
  input  logic          mem_ack,
  output logic          timeout
);
  typedef enum logic [1:0] {IDLE, V1, V2, CPU} state_t;
  localparam int WW = $clog2(MAX_WAIT + 2);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WSAT = WW'(MAX_WAIT + 1);
  state_t state_q, state_d;
  logic [2*AW-1:0] cur, last_q, last_d, pair_q, pair_d;
  logic chg, fire;
  logic pending_q, pending_d, stale_q, stale_d, req_q, req_d;
  logic valid_q, valid_d, ack_q, ack_d, timeout_q, timeout_d;
  logic [15:0] sh_q, sh_d, d1_q, d1_d, d2_q, d2_d, cdout_q, cdout_d, cdin_q, cdin_d;
  logic [AW-1:0] caddr_q, caddr_d;
  logic cwe_q, cwe_d;
  logic [1:0] cbe_q, cbe_d;
  logic [WW-1:0] wait_q, wait_d;
  always_comb begin
    cur       = {vram_addr1, vram_addr2};
    chg       = fetch_en && (cur != last_q);
    fire      = req_q && mem_ack;
    last_d    = chg ? cur : last_q;
    pending_d = fetch_en && (pending_q || chg);
    // a fetch whose pair moved on, or whose fetching was disabled, must not be published
    stale_d   = stale_q || ((state_q == V1 || state_q == V2) && (chg || !fetch_en));
    req_d     = (state_q != IDLE) && !fire;
    wait_d    = !req_q ? '0 : (wait_q == WSAT ? wait_q : wait_q + 1'b1);
    timeout_d = timeout_q || (wait_d > WMAX);
    state_d   = state_q;
    pair_d    = pair_q;
    sh_d      = sh_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    valid_d   = 1'b0;
    ack_d     = 1'b0;
    cdout_d   = cdout_q;
    caddr_d   = caddr_q;
    cwe_d     = cwe_q;
    cbe_d     = cbe_q;
    cdin_d    = cdin_q;
    case (state_q)
      IDLE: begin
        if (pending_d) begin
          state_d = V1;
          pair_d  = last_d;
          stale_d = 1'b0;
        end else if (cpu_req) begin
          state_d = CPU;
          caddr_d = cpu_addr;
          cwe_d   = cpu_we;
          cbe_d   = cpu_be;
          cdin_d  = cpu_din;
        end
      end
      V1: if (fire) begin
        sh_d    = mem_dout;
        state_d = stale_d ? IDLE : V2;
      end
      V2: if (fire) begin
        state_d = IDLE;
        if (!stale_d) begin
          d1_d      = sh_q;
          d2_d      = mem_dout;
          valid_d   = 1'b1;
          pending_d = 1'b0;
        end
      end
      default: if (fire) begin
        cdout_d = mem_dout;
        ack_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= '1;
      pair_q    <= '0;
      pending_q <= 1'b0;
      stale_q   <= 1'b0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
      sh_q      <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
      cdout_q   <= '0;
      cdin_q    <= '0;
      caddr_q   <= '0;
      cwe_q     <= 1'b0;
      cbe_q     <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      pair_q    <= pair_d;
      pending_q <= pending_d;
      stale_q   <= stale_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
      sh_q      <= sh_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      cdout_q   <= cdout_d;
      cdin_q    <= cdin_d;
      caddr_q   <= caddr_d;
      cwe_q     <= cwe_d;
      cbe_q     <= cbe_d;
      wait_q    <= wait_d;
    end
  end
  assign vram_dout1 = d1_q;
  assign vram_dout2 = d2_q;
  assign vram_valid = valid_q;
  assign cpu_dout   = cdout_q;
  assign cpu_ack    = ack_q;
  assign mem_req    = req_q;
  assign timeout    = timeout_q;
  assign mem_addr   = state_q == V1 ? pair_q[2*AW-1:AW] : state_q == V2 ? pair_q[AW-1:0] :
                      state_q == CPU ? caddr_q : '0;
  assign mem_we     = (state_q == CPU) && cwe_q;
  assign mem_be     = state_q == CPU ? cbe_q : state_q == IDLE ? 2'b00 : 2'b11;
  assign mem_din    = state_q == CPU ? cdin_q : '0;
endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// tb_vram_fetch_arbiter: directed checks of video/CPU arbitration against a latency-programmable memory model.
module tb_vram_fetch_arbiter;
  localparam int AW = 19;
  logic clk_sys = 1'b0, reset = 1'b1, fetch_en = 1'b0;
  logic [AW-1:0] vram_addr1 = '0, vram_addr2 = '0, cpu_addr = '0, mem_addr;
  logic [15:0] vram_dout1, vram_dout2, cpu_dout, mem_din, cpu_din = '0, mem_dout = '0;
  logic vram_valid, cpu_ack, mem_req, mem_we, timeout;
  logic cpu_req = 1'b0, cpu_we = 1'b0, mem_ack = 1'b0;
  logic [1:0] cpu_be = '0, mem_be;
  int n_tests = 0, n_fail = 0;
  int lat = 2, cnt = 0, vcnt = 0, acnt = 0, incoh = 0;
  logic to_at6 = 1'b0;
  logic [15:0] p1 = '0, p2 = '0;
  logic [AW-1:0] log_addr[$];
  logic log_we[$];
  logic [1:0] log_be[$];
  logic [15:0] log_din[$];

  vram_fetch_arbiter #(.AW(AW), .MAX_WAIT(6)) dut (
    .clk_sys(clk_sys), .reset(reset), .fetch_en(fetch_en),
    .vram_addr1(vram_addr1), .vram_addr2(vram_addr2),
    .vram_dout1(vram_dout1), .vram_dout2(vram_dout2), .vram_valid(vram_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack), .timeout(timeout)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [15:0] md(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // memory model: acks in the lat-th cycle of mem_req and logs each transaction
  always @(negedge clk_sys) begin
    if (mem_req && !mem_ack) begin
      cnt = cnt + 1;
      if (cnt == 6) to_at6 = timeout;
      if (cnt == lat) begin
        mem_ack = 1'b1;
        mem_dout = md(mem_addr);
        log_addr.push_back(mem_addr);
        log_we.push_back(mem_we);
        log_be.push_back(mem_be);
        log_din.push_back(mem_din);
      end
    end else begin
      mem_ack = 1'b0;
      cnt = 0;
    end
  end

  always @(negedge clk_sys) begin
    if (vram_valid) vcnt = vcnt + 1;
    if (cpu_ack) acnt = acnt + 1;
    if ((vram_dout1 !== p1 || vram_dout2 !== p2) && !vram_valid) incoh = incoh + 1;
    p1 = vram_dout1;
    p2 = vram_dout2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_sig(input int which, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk_sys);
      ok = which == 0 ? vram_valid : which == 1 ? cpu_ack : mem_req;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk_sys);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_valid", 32'(vram_valid), 32'd0);
    chk("rst_dout1", 32'(vram_dout1), 32'd0);
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);

    fetch_en = 1'b1;
    vram_addr1 = 19'h00100;
    vram_addr2 = 19'h00180;
    wait_sig(0, "s1_wait_valid");
    repeat (3) @(negedge clk_sys);
    chk("s1_nlog", 32'(log_addr.size()), 32'd2);
    chk("s1_a0", 32'(log_addr[0]), 32'h00100);
    chk("s1_a1", 32'(log_addr[1]), 32'h00180);
    chk("s1_we", 32'(log_we[0]), 32'd0);
    chk("s1_dout1", 32'(vram_dout1), 32'h5B5A);
    chk("s1_dout2", 32'(vram_dout2), 32'h5BDA);
    chk("s1_vcnt", 32'(vcnt), 32'd1);

    vram_addr1 = 19'h00200;
    vram_addr2 = 19'h00280;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 19'h12345;
    wait_sig(1, "s2_wait_ack");
    cpu_req = 1'b0;
    chk("s2_cpu_dout", 32'(cpu_dout), 32'h791F);
    repeat (3) @(negedge clk_sys);
    chk("s2_nlog", 32'(log_addr.size()), 32'd5);
    chk("s2_a2", 32'(log_addr[2]), 32'h00200);
    chk("s2_a3", 32'(log_addr[3]), 32'h00280);
    chk("s2_a4", 32'(log_addr[4]), 32'h12345);
    chk("s2_vcnt", 32'(vcnt), 32'd2);
    chk("s2_acnt", 32'(acnt), 32'd1);
    chk("s2_dout1", 32'(vram_dout1), 32'h585A);
    chk("s2_dout2", 32'(vram_dout2), 32'h58DA);

    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_be = 2'b10;
    cpu_addr = 19'h00042;
    cpu_din = 16'hBEEF;
    wait_sig(2, "s3_wait_req");
    vram_addr1 = 19'h00300;
    vram_addr2 = 19'h00380;
    wait_sig(1, "s3_wait_ack");
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    wait_sig(0, "s3_wait_valid");
    repeat (3) @(negedge clk_sys);
    chk("s3_nlog", 32'(log_addr.size()), 32'd8);
    chk("s3_waddr", 32'(log_addr[5]), 32'h00042);
    chk("s3_we", 32'(log_we[5]), 32'd1);
    chk("s3_be", 32'(log_be[5]), 32'd2);
    chk("s3_din", 32'(log_din[5]), 32'hBEEF);
    chk("s3_a6", 32'(log_addr[6]), 32'h00300);
    chk("s3_a7", 32'(log_addr[7]), 32'h00380);
    chk("s3_dout1", 32'(vram_dout1), 32'h595A);
    chk("s3_dout2", 32'(vram_dout2), 32'h59DA);
    chk("s3_vcnt", 32'(vcnt), 32'd3);

    vram_addr1 = 19'h00400;
    vram_addr2 = 19'h00480;
    wait_sig(2, "s4_wait_req");
    vram_addr1 = 19'h00500;
    vram_addr2 = 19'h00580;
    wait_sig(0, "s4_wait_valid");
    repeat (3) @(negedge clk_sys);
    chk("s4_nlog", 32'(log_addr.size()), 32'd11);
    chk("s4_a8", 32'(log_addr[8]), 32'h00400);
    chk("s4_a9", 32'(log_addr[9]), 32'h00500);
    chk("s4_a10", 32'(log_addr[10]), 32'h00580);
    chk("s4_vcnt", 32'(vcnt), 32'd4);
    chk("s4_dout1", 32'(vram_dout1), 32'h5F5A);
    chk("s4_dout2", 32'(vram_dout2), 32'h5FDA);
    chk("s4_incoh", 32'(incoh), 32'd0);

    fetch_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vram_addr1 = 19'(19'h00600 + i * 64);
      vram_addr2 = 19'(19'h00680 + i * 64);
      repeat (2) @(negedge clk_sys);
    end
    chk("s5_nlog_idle", 32'(log_addr.size()), 32'd11);
    cpu_req = 1'b1;
    cpu_addr = 19'h00777;
    wait_sig(1, "s5_wait_ack");
    cpu_req = 1'b0;
    chk("s5_cpu_dout", 32'(cpu_dout), 32'h5D2D);
    repeat (3) @(negedge clk_sys);
    chk("s5_nlog", 32'(log_addr.size()), 32'd12);
    chk("s5_a11", 32'(log_addr[11]), 32'h00777);
    chk("s5_vcnt", 32'(vcnt), 32'd4);
    chk("s5_dout1", 32'(vram_dout1), 32'h5F5A);
    chk("s5_timeout", 32'(timeout), 32'd0);

    lat = 8;
    cpu_req = 1'b1;
    cpu_addr = 19'h00999;
    wait_sig(1, "s6_wait_ack");
    cpu_req = 1'b0;
    chk("s6_cpu_dout", 32'(cpu_dout), 32'h53C3);
    chk("s6_to_at6", 32'(to_at6), 32'd0);
    chk("s6_timeout", 32'(timeout), 32'd1);
    repeat (3) @(negedge clk_sys);
    chk("s6_acnt", 32'(acnt), 32'd4);
    chk("s6_timeout_sticky", 32'(timeout), 32'd1);
    chk("s6_incoh", 32'(incoh), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
